regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter PROT_MASK, default 32'h0C000001; bit n set means register $n is write-protected ($0, $26, $27).
REQ-002 Parameter CNT_W, default 8; width of the drop counter.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset; synchronous, active-high.
REQ-005 Hold  input  1  pipeline freeze; blocks all grants while high.
REQ-006 A_Valid  input  1  ALU writeback request.
REQ-007 A_Addr  input  5  ALU destination register.
REQ-008 A_Data  input  32  ALU result, signed.
REQ-009 A_Ready  output  1  ALU request accepted this cycle.
REQ-010 B_Valid, B_Addr, B_Data, B_Ready  same widths as A  load writeback requester.
REQ-011 RegWrite  output  1  write strobe to register file.
REQ-012 WAddr  output  5  register-file write address.
REQ-013 WData  output  32  register-file write data.
REQ-014 Drop  output  1  one-cycle pulse: accepted request targeted a protected register.
REQ-015 DropCount  output  CNT_W  saturating count of dropped writes.

Function
REQ-016 Transfer on a port SHALL occur exactly in a cycle where X_Valid=1 and X_Ready=1.
REQ-017 X_Ready SHALL be combinational: 1 only when X_Valid=1, Hold=0, Rst=0 and X holds the grant.
REQ-018 At most one of A_Ready/B_Ready SHALL be 1 in any cycle.
REQ-019 Only one valid: that port SHALL be granted.
REQ-020 Both valid: the port named by priority pointer Pri SHALL be granted (Pri=0 favours A, Pri=1 favours B).
REQ-021 After any transfer, Pri SHALL point to the port that did not transfer; with no transfer, Pri SHALL hold.
REQ-022 Hold=1 SHALL produce no grant, no Pri change, and RegWrite=0 on the next cycle.
REQ-023 A transfer to a non-protected address SHALL drive RegWrite=1, WAddr=addr, WData=data for exactly the following cycle (latency 1, registered).
REQ-024 A transfer to a protected address (PROT_MASK[addr]=1) SHALL be accepted (Ready=1), give RegWrite=0 and Drop=1 the following cycle, and increment DropCount.
REQ-025 DropCount SHALL saturate at all-ones and not wrap.
REQ-026 In cycles without a transfer, RegWrite=0 and Drop=0; WAddr/WData SHALL hold their last values.
REQ-027 Back-to-back transfers SHALL yield RegWrite=1 on consecutive cycles; throughput is one write per cycle.
REQ-028 A Valid deasserted without Ready SHALL be legal; the arbiter keeps no pending state for it.

Reset
REQ-029 While Rst=1: A_Ready=B_Ready=0, Pri=0, and on the next edge RegWrite=0, WAddr=0, WData=0, Drop=0, DropCount=0.
REQ-030 Rst asserted in the cycle of a transfer SHALL discard it; no RegWrite or Drop follows.
REQ-031 Rst SHALL take priority over Hold and all requests.

Structure
REQ-032 A shared package SHALL hold REG_ZERO=0, REG_K0=26, REG_K1=27, REG_ADDR_W=5, REG_DATA_W=32 and the default PROT_MASK.
REQ-033 The two-way round-robin grant and the Pri flop SHALL form one sub-module, rr_arb2; filtering, output registers and the counter stay in the top.

Verification
REQ-034 A_Valid=1, A_Addr=5, A_Data=-7, B idle -> A_Ready=1 same cycle; next cycle RegWrite=1, WAddr=5, WData=-7.
REQ-035 Both valid for 4 cycles from reset (A_Addr=3, B_Addr=4) -> grants A,B,A,B; RegWrite=1 on 4 consecutive cycles.
REQ-036 A_Addr=0, then 26, then 27 -> each accepted, RegWrite=0, Drop=1, DropCount ends at 3.
REQ-037 Hold=1 with both valid for 2 cycles -> Ready=0 and RegWrite=0 throughout; after Hold drops, Pri is unchanged and the favoured port is granted first.
REQ-038 Rst=1 in the same cycle as a B transfer to $9 -> no RegWrite follows; DropCount=0 and Pri=0 afterwards.
REQ-039 260 protected writes -> DropCount stays 255 after the 255th.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter slice.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_K0   = 5'd26;
  localparam logic [REG_ADDR_W-1:0] REG_K1   = 5'd27;

  // $0 is hardwired zero; $k0/$k1 are reserved for the kernel.
  localparam logic [31:0] DEF_PROT_MASK = (32'd1 << REG_ZERO)
                                        | (32'd1 << REG_K0)
                                        | (32'd1 << REG_K1);

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a single priority-pointer flop.
module rr_arb2
  import regfile_write_arbiter_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic Hold,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic pri;
  logic en;

  // Grants are combinational so a requester sees acceptance in its own cycle.
  always_comb begin
    en    = ~Rst & ~Hold;
    gnt_a = en & req_a & (~req_b | ~pri);
    gnt_b = en & req_b & (~req_a |  pri);
  end

  // Pointer moves to the port that lost; it holds when nothing transfers.
  always_ff @(posedge Clk) begin
    if (Rst)        pri <= 1'b0;
    else if (gnt_a) pri <= 1'b1;
    else if (gnt_b) pri <= 1'b0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write
// port, silently dropping (and counting) writes to protected registers.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter logic [31:0] PROT_MASK = DEF_PROT_MASK,
  parameter int          CNT_W     = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Hold,
  input  logic                         A_Valid,
  input  logic [REG_ADDR_W-1:0]        A_Addr,
  input  logic signed [REG_DATA_W-1:0] A_Data,
  output logic                         A_Ready,
  input  logic                         B_Valid,
  input  logic [REG_ADDR_W-1:0]        B_Addr,
  input  logic signed [REG_DATA_W-1:0] B_Data,
  output logic                         B_Ready,
  output logic                         RegWrite,
  output logic [REG_ADDR_W-1:0]        WAddr,
  output logic signed [REG_DATA_W-1:0] WData,
  output logic                         Drop,
  output logic [CNT_W-1:0]             DropCount
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                         gnt_a_p0, gnt_b_p0;
  logic                         xfer_p0, prot_p0;
  logic [REG_ADDR_W-1:0]        addr_p0;
  logic signed [REG_DATA_W-1:0] data_p0;

  logic                         vld_p1, drop_p1;
  logic [REG_ADDR_W-1:0]        waddr_p1;
  logic signed [REG_DATA_W-1:0] wdata_p1;
  logic [CNT_W-1:0]             cnt_p1;

  rr_arb2 u_arb (
    .Clk   (Clk),
    .Rst   (Rst),
    .Hold  (Hold),
    .req_a (A_Valid),
    .req_b (B_Valid),
    .gnt_a (gnt_a_p0),
    .gnt_b (gnt_b_p0)
  );

  assign A_Ready = gnt_a_p0;
  assign B_Ready = gnt_b_p0;

  // Stage p0: mux the granted request and classify its destination.
  always_comb begin
    xfer_p0 = gnt_a_p0 | gnt_b_p0;
    addr_p0 = gnt_b_p0 ? B_Addr : A_Addr;
    data_p0 = gnt_b_p0 ? B_Data : A_Data;
    prot_p0 = PROT_MASK[addr_p0];
  end

  // Stage p1: registered write strobe, payload, drop pulse and drop counter.
  // Address/data only update on a real write so protected values never leak.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p1   <= 1'b0;
      drop_p1  <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      cnt_p1   <= '0;
    end else begin
      vld_p1  <= xfer_p0 & ~prot_p0;
      drop_p1 <= xfer_p0 &  prot_p0;
      if (xfer_p0 && !prot_p0) begin
        waddr_p1 <= addr_p0;
        wdata_p1 <= data_p0;
      end
      if (xfer_p0 && prot_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign RegWrite  = vld_p1;
  assign Drop      = drop_p1;
  assign WAddr     = waddr_p1;
  assign WData     = wdata_p1;
  assign DropCount = cnt_p1;

endmodule
